decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32/RV64 instruction decode stage between fetch and register read.
//  Splits fields, classifies the format, builds the sign-extended XLEN immediate,
//  flags illegal encodings and derives register-use / write-enable hints.
//  valid/ready on both sides, 2-entry skid buffer: full throughput, registered in_ready.
// PARAMETERS
//  XLEN        32  datapath/immediate/PC width; legal values 32 or 64
//  REG_ADDR_W  5   register index width (5 for RV32I/RV64I)
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           asynchronous reset, active low
//  flush        in   1           synchronous kill of all buffered entries
//  in_valid     in   1           instruction/PC valid
//  in_ready     out  1           stage can accept (registered)
//  in_instr     in   32          raw instruction word
//  in_pc        in   XLEN        PC of in_instr
//  out_valid    out  1           decoded entry valid
//  out_ready    in   1           downstream accepts
//  out_pc       out  XLEN        PC passthrough
//  out_itype    out  3           instr_type_e: R,I,S,B,U,J,ILL(7)
//  out_opcode   out  7           instr[6:0]
//  out_funct3   out  3           instr[14:12]
//  out_funct7   out  7           instr[31:25]
//  out_rs1      out  REG_ADDR_W  instr[19:15]
//  out_rs2      out  REG_ADDR_W  instr[24:20]
//  out_rd       out  REG_ADDR_W  instr[11:7]
//  out_imm      out  XLEN        format immediate, sign-extended from instr[31]
//  out_rs1_use  out  1           rs1 is a true source
//  out_rs2_use  out  1           rs2 is a true source (R,S,B)
//  out_rd_we    out  1           writes rd; 0 if rd==0, S, B or ILL
//  out_illegal  out  1           illegal/unsupported encoding
//  out_muldiv   out  1           M-extension op (see CONFIGURATION)
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, skid empty, all data outputs 0.
//  Latency: accepted (in_valid&&in_ready) at edge N -> out_valid from N+1.
//  Skid: main reg + skid reg. Transfer out on out_valid&&out_ready. If main held and
//   not drained while input accepted, new entry -> skid; in_ready = !skid_full (reg).
//   Skid promotes to main on drain. In-order; no entry dropped or duplicated.
//  Simultaneous accept+drain with skid empty: main replaced, skid stays empty.
//  flush: next edge out_valid=0, skid empty, in_ready=1; input that cycle discarded.
//  flush wins over accept; reset mid-transfer discards all entries.
//  Decode is combinational on in_instr, captured in regs; outputs stable while
//   out_valid&&!out_ready.
//  Immediates: I=[31:20]; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0};
//   U={[31:12],12'b0}; J={[31],[19:12],[20],[30:21],0}; R/ILL -> 0.
//  Legal opcodes: LUI,AUIPC(U) JAL(J) JALR,LOAD,OP-IMM,MISC-MEM,SYSTEM(I)
//   BRANCH(B) STORE(S) OP(R); XLEN=64 adds OP-IMM-32,OP-32.
//  Illegal: instr[1:0]!=2'b11; unknown opcode; instr==0 or all ones; OP funct7
//   not 0000000/0100000 (0100000 only with funct3 000/101); shift-imm upper bits
//   bad (funct7 for XLEN=32, funct6 for XLEN=64); BRANCH funct3 010/011; JALR funct3!=0.
//   Illegal -> itype=ILL, rd_we=0, rs*_use=0, imm=0; fields still passed through.
//  rs1_use=0 for LUI, AUIPC, JAL, ILL.
// CONFIGURATION
//  DECODE_M_EXT_EN defined: OP/OP-32 with funct7=0000001 legal, itype=R,
//   out_muldiv=1. Undefined: that encoding illegal, out_muldiv tied 0.
// STRUCTURE
//  riscv_pkg: instr_type_e, opcode localparams, decoded_t struct (one skid entry).
//  Sub-module imm_gen (comb: instr + itype -> XLEN immediate).
//  Handshake/skid logic and legality checks stay in decode_stage.
// TESTING
//  ADDI x1,x0,-1 (0xFFF00093) -> itype=I, rd=1, imm=all ones, rd_we=1, 1-cycle latency.
//  SW x2,8(x1) (0x0020A423) -> itype=S, imm=8, rs2_use=1, rd_we=0.
//  BEQ backward (0xFE000EE3) -> itype=B, imm=-4; JAL x0 +0x800 -> rd_we=0, imm=0x800.
//  0x00000000, 0x02208033 (MUL) -> illegal=1 / muldiv=1 with DECODE_M_EXT_EN, else illegal.
//  out_ready low 3 cycles, in_valid streaming -> in_ready drops after 2, no loss, order kept.
//  flush with both entries full -> next cycle out_valid=0, in_ready=1; async rst_n mid-stream.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32/RV64 decode stage.
//   instr_type_e : instruction format class (R,I,S,B,U,J,ILL)
//   OPC_*        : major opcodes recognised by the decoder
//   FUNCT7_*     : funct7 encodings used in legality checks
//   decoded_t    : XLEN-independent decode fields of one buffered entry
//                  (PC and immediate are stored next to it, sized by XLEN)
package riscv_pkg;

  typedef enum logic [2:0] {
    ITYPE_R   = 3'd0,
    ITYPE_I   = 3'd1,
    ITYPE_S   = 3'd2,
    ITYPE_B   = 3'd3,
    ITYPE_U   = 3'd4,
    ITYPE_J   = 3'd5,
    ITYPE_ILL = 3'd7
  } instr_type_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    instr_type_e itype;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_use;
    logic        rs2_use;
    logic        rd_we;
    logic        illegal;
    logic        muldiv;
  } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate builder.
//   instr [31:7] : instruction word above the opcode (opcode is not needed here)
//   itype        : format class; R and ILL produce a zero immediate
//   imm   [XLEN] : immediate, sign-extended from instr[31] to XLEN
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  instr_type_e     itype,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate for each format
  always_comb begin
    imm32 = 32'h0000_0000;
    case (itype)
      ITYPE_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      ITYPE_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ITYPE_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ITYPE_U: imm32 = {instr[31:12], 12'h000};
      ITYPE_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'h0000_0000;
    endcase
  end

  // Signed size cast widens to XLEN by replicating bit 31
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 decode stage with a 2-entry skid buffer.
//   clk, rst_n (async, active low), flush (sync kill of buffered entries)
//   in_valid / in_ready (registered) / in_instr / in_pc : fetch side
//   out_valid / out_ready / out_* decoded fields       : register-read side
// Optional feature: define DECODE_M_EXT_EN to accept M-extension OP/OP-32
// encodings (funct7=0000001) and raise out_muldiv; otherwise they are illegal.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [2:0]            out_itype,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_rs1_use,
  output logic                  out_rs2_use,
  output logic                  out_rd_we,
  output logic                  out_illegal,
  output logic                  out_muldiv
);

`ifdef DECODE_M_EXT_EN
  localparam bit M_EXT_EN = 1'b1;
`else
  localparam bit M_EXT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } entry_t;

  // ---------------- combinational decode of in_instr ----------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_shift;
  logic            upper7_ok;
  logic            upper6_ok;
  logic            op_imm_ok;
  logic            op_imm32_ok;
  logic            op_ok;
  logic            muldiv_enc;
  logic            fmt_ok;
  logic            illegal;
  instr_type_e     itype_raw;
  instr_type_e     itype;
  logic [XLEN-1:0] imm;
  entry_t          new_entry;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Shift-immediates: only SRAI may set the "alt" bit; RV64 has a 6-bit shamt
  assign is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign upper7_ok   = (funct7 == FUNCT7_BASE) ||
                       ((funct3 == 3'b101) && (funct7 == FUNCT7_ALT));
  assign upper6_ok   = (in_instr[31:26] == 6'b000000) ||
                       ((funct3 == 3'b101) && (in_instr[31:26] == 6'b010000));
  assign op_imm_ok   = !is_shift || ((XLEN == 64) ? upper6_ok : upper7_ok);
  assign op_imm32_ok = !is_shift || upper7_ok;

  // Register-register ops: SUB/SRA use funct7 alt, mul/div only when enabled
  assign muldiv_enc = M_EXT_EN && (funct7 == FUNCT7_MULDIV);
  assign op_ok      = (funct7 == FUNCT7_BASE) ||
                      ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                      muldiv_enc;

  // Classify the format and check per-opcode legality
  always_comb begin
    itype_raw = ITYPE_ILL;
    fmt_ok    = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        itype_raw = ITYPE_U;
        fmt_ok    = 1'b1;
      end
      OPC_JAL: begin
        itype_raw = ITYPE_J;
        fmt_ok    = 1'b1;
      end
      OPC_JALR: begin
        itype_raw = ITYPE_I;
        fmt_ok    = (funct3 == 3'b000);
      end
      OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
        itype_raw = ITYPE_I;
        fmt_ok    = 1'b1;
      end
      OPC_OP_IMM: begin
        itype_raw = ITYPE_I;
        fmt_ok    = op_imm_ok;
      end
      OPC_BRANCH: begin
        itype_raw = ITYPE_B;
        fmt_ok    = !((funct3 == 3'b010) || (funct3 == 3'b011));
      end
      OPC_STORE: begin
        itype_raw = ITYPE_S;
        fmt_ok    = 1'b1;
      end
      OPC_OP: begin
        itype_raw = ITYPE_R;
        fmt_ok    = op_ok;
      end
      OPC_OP_IMM_32: begin
        itype_raw = ITYPE_I;
        fmt_ok    = (XLEN == 64) && op_imm32_ok;
      end
      OPC_OP_32: begin
        itype_raw = ITYPE_R;
        fmt_ok    = (XLEN == 64) && op_ok;
      end
      default: begin
        itype_raw = ITYPE_ILL;
        fmt_ok    = 1'b0;
      end
    endcase
  end

  assign illegal = !fmt_ok || (in_instr[1:0] != 2'b11) ||
                   (in_instr == 32'h0000_0000) || (in_instr == 32'hFFFF_FFFF);
  assign itype   = illegal ? ITYPE_ILL : itype_raw;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .itype (itype),
    .imm   (imm)
  );

  // Pack the decoded candidate entry; hints are forced low for illegal words
  always_comb begin
    new_entry             = '0;
    new_entry.pc          = in_pc;
    new_entry.imm         = imm;
    new_entry.dec.itype   = itype;
    new_entry.dec.opcode  = opcode;
    new_entry.dec.funct3  = funct3;
    new_entry.dec.funct7  = funct7;
    new_entry.dec.rs1     = in_instr[19:15];
    new_entry.dec.rs2     = in_instr[24:20];
    new_entry.dec.rd      = in_instr[11:7];
    new_entry.dec.rs1_use = !illegal && (itype != ITYPE_U) && (itype != ITYPE_J);
    new_entry.dec.rs2_use = !illegal && ((itype == ITYPE_R) || (itype == ITYPE_S) ||
                                         (itype == ITYPE_B));
    new_entry.dec.rd_we   = !illegal && (in_instr[11:7] != 5'd0) &&
                            (itype != ITYPE_S) && (itype != ITYPE_B);
    new_entry.dec.illegal = illegal;
    new_entry.dec.muldiv  = !illegal && muldiv_enc &&
                            ((opcode == OPC_OP) || (opcode == OPC_OP_32));
  end

  // ---------------- skid buffer: main + skid register ----------------
  entry_t main_r, main_n;
  entry_t skid_r, skid_n;
  logic   main_valid_r, main_valid_n;
  logic   skid_valid_r, skid_valid_n;
  logic   in_ready_r;
  logic   accept;
  logic   drain;

  assign accept = in_valid && in_ready_r;
  assign drain  = main_valid_r && out_ready;

  // Next-state for the two entries; the skid only fills when main is stuck
  always_comb begin
    main_n       = main_r;
    skid_n       = skid_r;
    main_valid_n = main_valid_r;
    skid_valid_n = skid_valid_r;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!main_valid_r || drain) begin
      if (skid_valid_r) begin
        // in_ready is low while skid is full, so no accept can coincide
        main_n       = skid_r;
        main_valid_n = 1'b1;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_n       = new_entry;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_n       = new_entry;
      skid_valid_n = 1'b1;
    end else begin
      skid_valid_n = skid_valid_r;
    end
  end

  // Entry and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_r       <= main_n;
      skid_r       <= skid_n;
      main_valid_r <= main_valid_n;
      skid_valid_r <= skid_valid_n;
      in_ready_r   <= !skid_valid_n;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = main_valid_r;
  assign out_pc      = main_r.pc;
  assign out_imm     = main_r.imm;
  assign out_itype   = main_r.dec.itype;
  assign out_opcode  = main_r.dec.opcode;
  assign out_funct3  = main_r.dec.funct3;
  assign out_funct7  = main_r.dec.funct7;
  assign out_rs1     = REG_ADDR_W'(main_r.dec.rs1);
  assign out_rs2     = REG_ADDR_W'(main_r.dec.rs2);
  assign out_rd      = REG_ADDR_W'(main_r.dec.rd);
  assign out_rs1_use = main_r.dec.rs1_use;
  assign out_rs2_use = main_r.dec.rs2_use;
  assign out_rd_we   = main_r.dec.rd_we;
  assign out_illegal = main_r.dec.illegal;
  assign out_muldiv  = main_r.dec.muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage (XLEN=32).
// Reference model: a 2-deep in-order FIFO of expected decode records, each
// computed from the RISC-V encoding rules. Build with DECODE_M_EXT_EN defined
// to check the M-extension configuration.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;

`ifdef DECODE_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_itype;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [RW-1:0]   out_rs1;
  logic [RW-1:0]   out_rs2;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_rs1_use;
  logic            out_rs2_use;
  logic            out_rd_we;
  logic            out_illegal;
  logic            out_muldiv;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_itype(out_itype), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_rs1_use(out_rs1_use), .out_rs2_use(out_rs2_use),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_muldiv(out_muldiv)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]      itype;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            rs1_use;
    logic            rs2_use;
    logic            rd_we;
    logic            illegal;
    logic            muldiv;
  } exp_t;

  exp_t q[$];

  localparam logic [6:0] OPS [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                      7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};

  // Expected decode of one word, straight from the ISA encoding rules (RV32)
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
    exp_t   e;
    byte    f;
    longint v;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    e.opcode = w[6:0]; e.f3 = f3; e.f7 = f7;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
    e.muldiv = 1'b0;
    case (w[6:0])
      7'h37, 7'h17:        f = "U";
      7'h6F:               f = "J";
      7'h67:               f = (f3 == 3'd0) ? "I" : "X";
      7'h03, 7'h0F, 7'h73: f = "I";
      7'h13: begin
        if (f3 == 3'd1)      f = (f7 == 7'h00) ? "I" : "X";
        else if (f3 == 3'd5) f = (f7 == 7'h00 || f7 == 7'h20) ? "I" : "X";
        else                 f = "I";
      end
      7'h63:               f = (f3 == 3'd2 || f3 == 3'd3) ? "X" : "B";
      7'h23:               f = "S";
      7'h33: begin
        if (f7 == 7'h00)                             f = "R";
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) f = "R";
        else if (M_EXT && f7 == 7'h01) begin f = "R"; e.muldiv = 1'b1; end
        else                                         f = "X";
      end
      default:             f = "X";
    endcase
    if (w == 32'h0 || w == 32'hFFFF_FFFF || w[1:0] != 2'b11) f = "X";
    if (f == "X") e.muldiv = 1'b0;
    case (f)
      "I": v = longint'($signed(w[31:20]));
      "S": v = longint'($signed({w[31:25], w[11:7]}));
      "B": v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      "U": v = longint'($signed({w[31:12], 12'h000}));
      "J": v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: v = 64'sd0;
    endcase
    e.imm = v[XLEN-1:0];
    case (f)
      "R": e.itype = 3'd0;
      "I": e.itype = 3'd1;
      "S": e.itype = 3'd2;
      "B": e.itype = 3'd3;
      "U": e.itype = 3'd4;
      "J": e.itype = 3'd5;
      default: e.itype = 3'd7;
    endcase
    e.illegal = (f == "X");
    e.rs1_use = (f == "R" || f == "I" || f == "S" || f == "B");
    e.rs2_use = (f == "R" || f == "S" || f == "B");
    e.rd_we   = !e.illegal && (w[11:7] != 5'd0) && (f != "S") && (f != "B");
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom();
    sel = $urandom_range(0, 15);
    if (sel < 13) w[6:0] = OPS[sel];
    else if (sel == 13) w = ($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
    if (sel < 13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: w[31:25] = w[31:25];
      endcase
    end
    return w;
  endfunction

  // Advance one clock: update the FIFO model from the driven inputs, then check
  task automatic step();
    bit fin, fout;
    fout = (q.size() != 0) && out_ready;
    fin  = in_valid && (q.size() < 2);
    if (flush) q.delete();
    else begin
      if (fout) void'(q.pop_front());
      if (fin) q.push_back(ref_decode(in_instr, in_pc));
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0) begin
      check_eq("pc", out_pc, q[0].pc);
      check_eq("itype", out_itype, q[0].itype);
      check_eq("opcode", out_opcode, q[0].opcode);
      check_eq("funct3", out_funct3, q[0].f3);
      check_eq("funct7", out_funct7, q[0].f7);
      check_eq("rs1", out_rs1, q[0].rs1);
      check_eq("rs2", out_rs2, q[0].rs2);
      check_eq("rd", out_rd, q[0].rd);
      check_eq("imm", out_imm, q[0].imm);
      check_eq("rs1_use", out_rs1_use, q[0].rs1_use);
      check_eq("rs2_use", out_rs2_use, q[0].rs2_use);
      check_eq("rd_we", out_rd_we, q[0].rd_we);
      check_eq("illegal", out_illegal, q[0].illegal);
      check_eq("muldiv", out_muldiv, q[0].muldiv);
    end
  endtask

  // Present one instruction for a single cycle with downstream ready
  task automatic send(input logic [31:0] w, input logic [XLEN-1:0] pc);
    in_valid  = 1'b1;
    in_instr  = w;
    in_pc     = pc;
    out_ready = 1'b1;
    flush     = 1'b0;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
    in_pc = '0; out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_imm", out_imm, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_itype", out_itype, 3'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed decodes with fixed expectations, one cycle after acceptance
    send(32'hFFF0_0093, 32'h0000_0100);
    check_eq("addi_valid", out_valid, 1'b1);
    check_eq("addi_itype", out_itype, 3'd1);
    check_eq("addi_rd", out_rd, 5'd1);
    check_eq("addi_imm", out_imm, 32'hFFFF_FFFF);
    check_eq("addi_rd_we", out_rd_we, 1'b1);
    step();
    send(32'h0020_A423, 32'h0000_0104);
    check_eq("sw_itype", out_itype, 3'd2);
    check_eq("sw_imm", out_imm, 32'h0000_0008);
    check_eq("sw_rs2_use", out_rs2_use, 1'b1);
    check_eq("sw_rd_we", out_rd_we, 1'b0);
    step();
    send(32'hFE00_0EE3, 32'h0000_0108);
    check_eq("beq_itype", out_itype, 3'd3);
    check_eq("beq_imm", out_imm, 32'hFFFF_FFFC);
    step();
    send(32'h0010_006F, 32'h0000_010C);
    check_eq("jal_itype", out_itype, 3'd5);
    check_eq("jal_imm", out_imm, 32'h0000_0800);
    check_eq("jal_rd_we", out_rd_we, 1'b0);
    check_eq("jal_rs1_use", out_rs1_use, 1'b0);
    step();
    send(32'h0000_0000, 32'h0000_0110);
    check_eq("zero_illegal", out_illegal, 1'b1);
    check_eq("zero_itype", out_itype, 3'd7);
    step();
    send(32'h0220_8033, 32'h0000_0114);
    check_eq("mul_illegal", out_illegal, !M_EXT);
    check_eq("mul_muldiv", out_muldiv, M_EXT);
    check_eq("mul_itype", out_itype, M_EXT ? 3'd0 : 3'd7);
    step();

    // Backpressure: out_ready low for 3 cycles while streaming
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = rand_instr();
      in_pc    = 32'h0000_0200 + 32'(4 * i);
      step();
      check_eq("stall_in_ready", in_ready, (i == 0) ? 1'b1 : 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      in_instr = rand_instr();
      in_pc    = 32'h0000_0200 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Flush with both entries occupied; the input offered that cycle is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = rand_instr();
      in_pc    = 32'h0000_0300 + 32'(4 * i);
      step();
    end
    flush = 1'b1;
    step();
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_in_ready", in_ready, 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = XLEN'($urandom()) & ~32'h3;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      step();
      if (c == 1000) begin
        rst_n = 1'b0;
        #2;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        q.delete();
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
